wb_pattern_master: RTL and testbench
====================================

# wb_pattern_master

Wishbone initiator that drives the SDRAM controller's Wishbone slave port with a self-checking write-then-readback traffic pattern. Issues a programmable number of incrementing bursts that write a deterministic data pattern, then re-reads the same region and compares every returned word. Sits on the application side of the SDRAM controller in place of a user client; used for bring-up and regression soak traffic.

## Interface
- `dw`, 32: Wishbone data width in bits (multiple of 8).
- `APP_AW`, 26: Wishbone byte-address width.
- `BL_MAX`, 8: maximum beats per burst (power of 2, ≥1).
- `wb_clk_i`  in  1: single clock; all logic on rising edge.
- `wb_rst_i`  in  1: reset, synchronous, active-high.
- `start`  in  1: begin a run; sampled only in IDLE.
- `base_addr`  in  APP_AW: byte start address, dw/8-aligned (low bits ignored).
- `burst_len`  in  $clog2(BL_MAX)+1: beats per burst, 1..BL_MAX.
- `num_bursts`  in  16: bursts per phase.
- `seed`  in  dw: pattern seed.
- `busy`  out  1: run in progress.
- `done`  out  1: run finished; held until next accepted `start`.
- `err_count`  out  16: mismatching read words, saturating.
- `first_err_addr`  out  APP_AW: byte address of first mismatch.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1: Wishbone cycle/strobe/write.
- `wb_addr_o`  out  APP_AW: byte address.
- `wb_dat_o`  out  dw: write data.
- `wb_sel_o`  out  dw/8: byte selects; all ones whenever `wb_stb_o`=1.
- `wb_cti_o`  out  3: cycle type; `wb_bte_o` out 2: fixed 2'b00 (linear).
- `wb_ack_i`  in  1; `wb_dat_i`  in  dw.

## Operation
- States: IDLE, WR, WR_GAP, RD, RD_GAP, DONE.
- IDLE: `start`=1 latches all config inputs; if `burst_len`==0 or `num_bursts`==0 go to DONE without bus activity, else go to WR; beat/burst counters and address cleared to latched base; `err_count` and `first_err_addr` cleared.
- WR: `wb_cyc_o`=`wb_stb_o`=`wb_we_o`=1. Each cycle with `wb_ack_i`=1 completes one beat: address += dw/8, beat counter +1. On last beat of burst go WR_GAP; after last beat of last burst go RD with address reloaded to base.
- WR_GAP / RD_GAP: exactly one cycle with `wb_cyc_o`=`wb_stb_o`=0, then back to WR / RD.
- RD: as WR with `wb_we_o`=0; on each ack compare `wb_dat_i` with expected pattern of current address; mismatch increments `err_count` (saturate at 16'hFFFF); first mismatch of the run captures `wb_addr_o` into `first_err_addr`. After last beat of last burst go DONE.
- DONE: `done`=1, `busy`=0; `start` accepted here as in IDLE.
- Pattern: word at byte address A = `seed` XOR zero-extended(A) (A truncated to dw if APP_AW>dw).
- `wb_cti_o`: 3'b010 for non-final beats of a burst, 3'b111 on final beat (including `burst_len`=1).
- Address arithmetic modulo 2^APP_AW; wrap past top is legal and silent.
- `wb_ack_i` ignored when `wb_stb_o`=0. No `wb_err_i`/retry support.

## Timing
- Reset values: all Wishbone outputs 0 (`wb_sel_o`, `wb_cti_o`, `wb_bte_o` 0), `busy`=0, `done`=0, `err_count`=0, `first_err_addr`=0; state IDLE.
- `start` high at edge N -> `wb_cyc_o`/`wb_stb_o` high after edge N, `busy` high same cycle.
- Outputs registered; address/data/cti advance in cycle after ack. Zero-wait-state slave: one beat per cycle within a burst.
- Burst of L beats with zero-wait slave occupies L cycles + 1 gap cycle.
- Final read ack at edge M -> `done`=1, `busy`=0 after edge M; `err_count` includes that beat.
- `wb_rst_i` mid-run: all outputs at reset values after that edge, regardless of pending ack; run is abandoned.
- `start` while busy: ignored.

## Test plan
- Reset: hold `wb_rst_i` during active WR -> next cycle `wb_cyc_o`=0, `busy`=0, `done`=0, `err_count`=0.
- Single-beat: base 0x100, `burst_len`=1, `num_bursts`=2, seed 0, zero-wait memory -> writes 0x100/0x104 data 0x100/0x104 with cti 3'b111, one gap cycle each, reads match, `done`=1, `err_count`=0.
- Full burst with wait states: `burst_len`=8, `num_bursts`=4, ack every 3rd cycle -> cti 010×7 then 111 per burst, 32 writes then 32 reads, `err_count`=0.
- Error injection: memory flips bit 0 of word at 0x208, base 0x200, `burst_len`=4, `num_bursts`=4 -> `err_count`=1, `first_err_addr`=0x208.
- Wrap: `APP_AW`=12, base 0xFF8, `burst_len`=4, `num_bursts`=1 -> addresses 0xFF8, 0xFFC, 0x000, 0x004; no errors.
- Degenerate: `num_bursts`=0 -> `done`=1 one cycle after `start`, `wb_cyc_o` never asserted.

Source files
------------

// File: rtl/wb_pattern_master.sv
// Wishbone initiator: writes a seed^address pattern in incrementing bursts,
// then reads the same region back and counts words that do not match.
module wb_pattern_master #(
    parameter int dw     = 32,
    parameter int APP_AW = 26,
    parameter int BL_MAX = 8
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    start,
    input  logic [APP_AW-1:0]       base_addr,
    input  logic [$clog2(BL_MAX):0] burst_len,
    input  logic [15:0]             num_bursts,
    input  logic [dw-1:0]           seed,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             err_count,
    output logic [APP_AW-1:0]       first_err_addr,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [APP_AW-1:0]       wb_addr_o,
    output logic [dw-1:0]           wb_dat_o,
    output logic [dw/8-1:0]         wb_sel_o,
    output logic [2:0]              wb_cti_o,
    output logic [1:0]              wb_bte_o,
    input  logic                    wb_ack_i,
    input  logic [dw-1:0]           wb_dat_i
);

    localparam int BLW  = $clog2(BL_MAX) + 1;
    localparam int STEP = dw / 8;
    localparam int PW   = (APP_AW > dw) ? APP_AW : dw;

    localparam logic [2:0] CTI_INC = 3'b010;
    localparam logic [2:0] CTI_END = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_GAP,
        S_RD,
        S_RD_GAP,
        S_DONE
    } state_t;

    state_t             state_reg;
    logic [APP_AW-1:0]  base_reg;
    logic [BLW-1:0]     blen_reg;
    logic [15:0]        nb_reg;
    logic [dw-1:0]      seed_reg;
    logic [BLW-1:0]     beat_reg;
    logic [15:0]        burst_reg;
    logic [APP_AW-1:0]  addr_reg;
    logic [dw-1:0]      dat_reg;
    logic               cyc_reg;
    logic               we_reg;
    logic               sel_reg;
    logic [2:0]         cti_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [15:0]        err_reg;
    logic [APP_AW-1:0]  first_reg;

    logic [APP_AW-1:0]  addr_next;
    logic [APP_AW-1:0]  base_aligned;
    logic               last_beat;
    logic               last_burst;
    logic [2:0]         cti_after;
    logic [2:0]         cti_first;
    logic               rd_mismatch;

    // Pattern word for a byte address: address zero-extended (or truncated) to dw.
    function automatic logic [dw-1:0] pattern_of(input logic [dw-1:0] s,
                                                 input logic [APP_AW-1:0] a);
        logic [PW-1:0] ext;
        ext = PW'(a);
        return s ^ ext[dw-1:0];
    endfunction

    assign base_aligned = base_addr & ~APP_AW'(STEP - 1);
    assign addr_next    = addr_reg + APP_AW'(STEP);
    assign last_beat    = (beat_reg == blen_reg - 1'b1);
    assign last_burst   = (burst_reg == nb_reg - 16'd1);
    // cti of the beat that follows the current one within the same burst
    assign cti_after    = (({1'b0, beat_reg} + (BLW+1)'(2)) == {1'b0, blen_reg}) ? CTI_END : CTI_INC;
    assign cti_first    = (blen_reg == BLW'(1)) ? CTI_END : CTI_INC;
    assign rd_mismatch  = (wb_dat_i != pattern_of(seed_reg, addr_reg));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg <= S_IDLE;
            base_reg  <= '0;
            blen_reg  <= '0;
            nb_reg    <= '0;
            seed_reg  <= '0;
            beat_reg  <= '0;
            burst_reg <= '0;
            addr_reg  <= '0;
            dat_reg   <= '0;
            cyc_reg   <= 1'b0;
            we_reg    <= 1'b0;
            sel_reg   <= 1'b0;
            cti_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= '0;
            first_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        base_reg  <= base_aligned;
                        blen_reg  <= burst_len;
                        nb_reg    <= num_bursts;
                        seed_reg  <= seed;
                        beat_reg  <= '0;
                        burst_reg <= '0;
                        addr_reg  <= base_aligned;
                        dat_reg   <= pattern_of(seed, base_aligned);
                        err_reg   <= '0;
                        first_reg <= '0;
                        if (burst_len == '0 || num_bursts == 16'd0) begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                        end else begin
                            state_reg <= S_WR;
                            done_reg  <= 1'b0;
                            busy_reg  <= 1'b1;
                            cyc_reg   <= 1'b1;
                            we_reg    <= 1'b1;
                            sel_reg   <= 1'b1;
                            cti_reg   <= (burst_len == BLW'(1)) ? CTI_END : CTI_INC;
                        end
                    end
                end

                S_WR: begin
                    if (wb_ack_i) begin
                        if (last_beat) begin
                            beat_reg <= '0;
                            cti_reg  <= cti_first;
                            if (last_burst) begin
                                // read phase starts straight away from the base
                                state_reg <= S_RD;
                                burst_reg <= '0;
                                addr_reg  <= base_reg;
                                we_reg    <= 1'b0;
                            end else begin
                                state_reg <= S_WR_GAP;
                                burst_reg <= burst_reg + 16'd1;
                                addr_reg  <= addr_next;
                                dat_reg   <= pattern_of(seed_reg, addr_next);
                                cyc_reg   <= 1'b0;
                                sel_reg   <= 1'b0;
                            end
                        end else begin
                            beat_reg <= beat_reg + 1'b1;
                            addr_reg <= addr_next;
                            dat_reg  <= pattern_of(seed_reg, addr_next);
                            cti_reg  <= cti_after;
                        end
                    end
                end

                S_WR_GAP: begin
                    state_reg <= S_WR;
                    cyc_reg   <= 1'b1;
                    sel_reg   <= 1'b1;
                end

                S_RD: begin
                    if (wb_ack_i) begin
                        if (rd_mismatch) begin
                            if (err_reg != 16'hFFFF) begin
                                err_reg <= err_reg + 16'd1;
                            end
                            if (err_reg == 16'd0) begin
                                first_reg <= addr_reg;
                            end
                        end
                        if (last_beat) begin
                            beat_reg <= '0;
                            cyc_reg  <= 1'b0;
                            sel_reg  <= 1'b0;
                            if (last_burst) begin
                                state_reg <= S_DONE;
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                                cti_reg   <= '0;
                            end else begin
                                state_reg <= S_RD_GAP;
                                burst_reg <= burst_reg + 16'd1;
                                addr_reg  <= addr_next;
                                cti_reg   <= cti_first;
                            end
                        end else begin
                            beat_reg <= beat_reg + 1'b1;
                            addr_reg <= addr_next;
                            cti_reg  <= cti_after;
                        end
                    end
                end

                S_RD_GAP: begin
                    state_reg <= S_RD;
                    cyc_reg   <= 1'b1;
                    sel_reg   <= 1'b1;
                end

                default: state_reg <= S_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < dw/8; gi++) begin : g_sel
            assign wb_sel_o[gi] = sel_reg;
        end
    endgenerate

    assign wb_cyc_o       = cyc_reg;
    assign wb_stb_o       = cyc_reg;
    assign wb_we_o        = we_reg;
    assign wb_addr_o      = addr_reg;
    assign wb_dat_o       = dat_reg;
    assign wb_cti_o       = cti_reg;
    assign wb_bte_o       = 2'b00;
    assign busy           = busy_reg;
    assign done           = done_reg;
    assign err_count      = err_reg;
    assign first_err_addr = first_reg;

endmodule

// File: tb/tb_wb_pattern_master.sv
// Bench for wb_pattern_master: behavioural Wishbone memory with programmable
// ack policy and bit-flip injection, checked against a transaction-list model.
module tb_wb_pattern_master;

    localparam int DW  = 32;
    localparam int AW  = 12;
    localparam int BLM = 8;
    localparam int LW  = $clog2(BLM) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [AW-1:0]     base_addr;
    logic [LW-1:0]     burst_len;
    logic [15:0]       num_bursts;
    logic [DW-1:0]     seed;
    logic              busy, done;
    logic [15:0]       err_count;
    logic [AW-1:0]     first_err_addr;
    logic              wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0]     wb_addr_o;
    logic [DW-1:0]     wb_dat_o;
    logic [DW/8-1:0]   wb_sel_o;
    logic [2:0]        wb_cti_o;
    logic [1:0]        wb_bte_o;
    logic              wb_ack_i = 1'b0;
    logic [DW-1:0]     wb_dat_i = '0;

    wb_pattern_master #(.dw(DW), .APP_AW(AW), .BL_MAX(BLM)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .base_addr(base_addr),
        .burst_len(burst_len), .num_bursts(num_bursts), .seed(seed),
        .busy(busy), .done(done), .err_count(err_count), .first_err_addr(first_err_addr),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o),
        .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
        logic [2:0]    cti;
    } txn_t;

    txn_t          obs_q[$];
    txn_t          exp_q[$];
    logic [DW-1:0] mem [logic [AW-1:0]];
    int            policy;
    int            cyc_cnt;
    bit            flip_en;
    logic [AW-1:0] flip_addr;
    bit            rec;
    int            gap_cnt, busy_cnt, bus_viol, cyc_seen;
    logic          ack_now;
    int            exp_err;
    logic [AW-1:0] exp_first;
    int            vectors, miscompares;

    // Memory slave: every output is stable between edges, so ack/data for the
    // next edge are chosen here and the beat that edge completes is logged.
    always @(negedge clk) begin
        cyc_cnt++;
        if (rec && busy && !wb_cyc_o) gap_cnt++;
        if (rec && busy) busy_cnt++;
        if (wb_cyc_o) cyc_seen++;
        if (wb_cyc_o !== wb_stb_o) bus_viol++;
        if (wb_stb_o && wb_sel_o !== '1) bus_viol++;
        if (wb_bte_o !== 2'b00) bus_viol++;
        case (policy)
            0:       ack_now = 1'b1;
            1:       ack_now = (cyc_cnt % 3 == 0);
            default: ack_now = ($urandom_range(0, 1) == 1);
        endcase
        ack_now  = ack_now && wb_cyc_o && wb_stb_o;
        wb_ack_i = ack_now;
        wb_dat_i = mem.exists(wb_addr_o) ? mem[wb_addr_o] : '0;
        if (flip_en && wb_addr_o == flip_addr) wb_dat_i[0] = ~wb_dat_i[0];
        if (ack_now) begin
            obs_q.push_back('{we: wb_we_o, addr: wb_addr_o,
                              dat: (wb_we_o ? wb_dat_o : '0), cti: wb_cti_o});
            if (wb_we_o) mem[wb_addr_o] = wb_dat_o;
        end
    end

    // Reference: full list of expected beats plus expected error summary.
    task automatic build_exp(input logic [AW-1:0] b, input int len, input int nb,
                             input logic [DW-1:0] s);
        logic [AW-1:0] ab, a;
        ab = b & ~AW'(3);
        exp_q.delete();
        exp_err = 0;
        exp_first = '0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int k = 0; k < nb * len; k++) begin
                a = ab + AW'(k * 4);
                exp_q.push_back('{we: (ph == 0), addr: a,
                                  dat: (ph == 0) ? (s ^ DW'(a)) : '0,
                                  cti: (k % len == len - 1) ? 3'b111 : 3'b010});
                if (ph == 1 && flip_en && a == flip_addr) begin
                    exp_err++;
                    if (exp_err == 1) exp_first = a;
                end
            end
        end
    endtask

    function automatic int first_diff();
        int n;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) return i;
        if (obs_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    // Drives one run and waits for done; optionally pokes start mid-run.
    task automatic do_run(input logic [AW-1:0] b, input int len, input int nb,
                          input logic [DW-1:0] s, input int pol, input bit poke,
                          output bit timed_out);
        obs_q.delete();
        gap_cnt = 0; busy_cnt = 0; bus_viol = 0; cyc_cnt = 0;
        policy = pol;
        @(negedge clk);
        base_addr = b; burst_len = LW'(len); num_bursts = 16'(nb); seed = s;
        start = 1'b1; rec = 1'b1;
        @(negedge clk);
        start = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (done) begin timed_out = 1'b0; break; end
            if (poke && i == 4 && busy) begin
                base_addr = AW'($urandom); burst_len = LW'($urandom_range(1, BLM));
                num_bursts = 16'($urandom_range(1, 3)); seed = $urandom; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        rec = 1'b0;
    endtask

    task automatic test_reset();
        logic [AW-1:0] b;
        vectors++;
        if ({busy, done, err_count, first_err_addr, wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o,
             wb_dat_o, wb_sel_o, wb_cti_o, wb_bte_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_values cyc=%b busy=%b done=%b err=%0d addr=%h cti=%b expected all zero",
                     wb_cyc_o, busy, done, err_count, wb_addr_o, wb_cti_o);
        end
        // Reset while writing
        policy = 0;
        b = 12'h040;
        base_addr = b; burst_len = 4'd8; num_bursts = 16'd4; seed = 32'hA5A5_0F0F;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (!(wb_cyc_o === 1'b1 && wb_we_o === 1'b1 && busy === 1'b1)) begin
            miscompares++;
            $display("FAIL reset_pre_wr cyc=%b we=%b busy=%b expected 1 1 1", wb_cyc_o, wb_we_o, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({busy, done, err_count, first_err_addr, wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o,
             wb_dat_o, wb_sel_o, wb_cti_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_wr cyc=%b busy=%b done=%b err=%0d addr=%h expected all zero",
                     wb_cyc_o, busy, done, err_count, wb_addr_o);
        end
        // Reset during readback after an error has been counted
        flip_en = 1'b1; flip_addr = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 300 && err_count == 16'd0; i++) @(negedge clk);
        vectors++;
        if (err_count !== 16'd1 || first_err_addr !== b || wb_we_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pre_rd err=%0d first=%h we=%b expected 1 %h 0",
                     err_count, first_err_addr, wb_we_o, b);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        flip_en = 1'b0;
        vectors++;
        if ({busy, done, err_count, first_err_addr, wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o,
             wb_sel_o, wb_cti_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_rd cyc=%b busy=%b err=%0d first=%h expected all zero",
                     wb_cyc_o, busy, err_count, first_err_addr);
        end
    endtask

    task automatic test_degenerate();
        for (int t = 0; t < 2; t++) begin
            cyc_seen = 0;
            @(negedge clk);
            base_addr = 12'h100; seed = 32'h1234;
            burst_len  = (t == 0) ? 4'd3 : 4'd0;
            num_bursts = (t == 0) ? 16'd0 : 16'd5;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            vectors++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL degenerate_%0d done=%b busy=%b expected 1 0", t, done, busy);
            end
            repeat (5) @(negedge clk);
            vectors++;
            if (cyc_seen != 0 || done !== 1'b1) begin
                miscompares++;
                $display("FAIL degenerate_bus_%0d cyc_cycles=%0d done=%b expected 0 1", t, cyc_seen, done);
            end
        end
    endtask

    task automatic test_single_beat();
        bit to; int d;
        flip_en = 1'b0;
        build_exp(12'h100, 1, 2, 32'h0);
        do_run(12'h100, 1, 2, 32'h0, 0, 1'b0, to);
        d = first_diff();
        vectors++;
        if (to || d != -1) begin
            miscompares++;
            $display("FAIL single_beat_txn timeout=%0b idx=%0d got %h expected %h", to, d,
                     (d >= 0) ? obs_q[d] : '0, (d >= 0) ? exp_q[d] : '0);
        end
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || err_count !== 16'd0 || first_err_addr !== '0) begin
            miscompares++;
            $display("FAIL single_beat_status done=%b busy=%b err=%0d first=%h expected 1 0 0 0",
                     done, busy, err_count, first_err_addr);
        end
        vectors++;
        if (gap_cnt != 2 || busy_cnt != 6 || bus_viol != 0) begin
            miscompares++;
            $display("FAIL single_beat_timing gaps=%0d busy_cycles=%0d viol=%0d expected 2 6 0",
                     gap_cnt, busy_cnt, bus_viol);
        end
    endtask

    task automatic test_wait_states();
        bit to; int d;
        flip_en = 1'b0;
        build_exp(12'h400, 8, 4, 32'hDEAD_BEEF);
        do_run(12'h400, 8, 4, 32'hDEAD_BEEF, 1, 1'b0, to);
        d = first_diff();
        vectors++;
        if (to || d != -1) begin
            miscompares++;
            $display("FAIL wait_states_txn timeout=%0b idx=%0d got %h expected %h", to, d,
                     (d >= 0) ? obs_q[d] : '0, (d >= 0) ? exp_q[d] : '0);
        end
        vectors++;
        if (done !== 1'b1 || err_count !== 16'd0 || gap_cnt != 6 || bus_viol != 0) begin
            miscompares++;
            $display("FAIL wait_states_status done=%b err=%0d gaps=%0d viol=%0d expected 1 0 6 0",
                     done, err_count, gap_cnt, bus_viol);
        end
    endtask

    task automatic test_error_inject();
        bit to; int d;
        flip_en = 1'b1; flip_addr = 12'h208;
        build_exp(12'h200, 4, 4, 32'h0F0F_F0F0);
        do_run(12'h200, 4, 4, 32'h0F0F_F0F0, 0, 1'b0, to);
        flip_en = 1'b0;
        d = first_diff();
        vectors++;
        if (to || d != -1) begin
            miscompares++;
            $display("FAIL error_inject_txn timeout=%0b idx=%0d got %h expected %h", to, d,
                     (d >= 0) ? obs_q[d] : '0, (d >= 0) ? exp_q[d] : '0);
        end
        vectors++;
        if (err_count !== 16'(exp_err) || first_err_addr !== 12'h208) begin
            miscompares++;
            $display("FAIL error_inject_count err=%0d first=%h expected %0d 208",
                     err_count, first_err_addr, exp_err);
        end
    endtask

    task automatic test_wrap();
        bit to; int d;
        flip_en = 1'b0;
        build_exp(12'hFF8, 4, 1, 32'h5555_AAAA);
        do_run(12'hFF8, 4, 1, 32'h5555_AAAA, 0, 1'b0, to);
        d = first_diff();
        vectors++;
        if (to || d != -1) begin
            miscompares++;
            $display("FAIL wrap_txn timeout=%0b idx=%0d got %h expected %h", to, d,
                     (d >= 0) ? obs_q[d] : '0, (d >= 0) ? exp_q[d] : '0);
        end
        vectors++;
        if (obs_q.size() < 4 || obs_q[2].addr !== 12'h000 || err_count !== 16'd0 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_addr third_addr=%h err=%0d done=%b expected 000 0 1",
                     (obs_q.size() > 2) ? obs_q[2].addr : 12'hXXX, err_count, done);
        end
    endtask

    // Random configs run back-to-back from DONE, with a start poked mid-run.
    task automatic test_back_to_back();
        bit to; int d, len, nb;
        logic [AW-1:0] b;
        logic [DW-1:0] s;
        for (int r = 0; r < 8; r++) begin
            b = AW'($urandom); len = $urandom_range(1, BLM); nb = $urandom_range(1, 4);
            s = $urandom;
            flip_en = ($urandom_range(0, 1) == 1);
            flip_addr = (b & ~AW'(3)) + AW'(4 * $urandom_range(0, nb * len - 1));
            build_exp(b, len, nb, s);
            do_run(b, len, nb, s, $urandom_range(0, 2), 1'b1, to);
            flip_en = 1'b0;
            d = first_diff();
            vectors++;
            if (to || d != -1) begin
                miscompares++;
                $display("FAIL random_%0d_txn base=%h len=%0d nb=%0d timeout=%0b idx=%0d got %h expected %h",
                         r, b, len, nb, to, d, (d >= 0) ? obs_q[d] : '0, (d >= 0) ? exp_q[d] : '0);
            end
            vectors++;
            if (err_count !== 16'(exp_err) || first_err_addr !== exp_first || done !== 1'b1 ||
                busy !== 1'b0 || gap_cnt != 2 * (nb - 1) || bus_viol != 0) begin
                miscompares++;
                $display("FAIL random_%0d_status err=%0d/%0d first=%h/%h done=%b busy=%b gaps=%0d/%0d viol=%0d",
                         r, err_count, exp_err, first_err_addr, exp_first, done, busy,
                         gap_cnt, 2 * (nb - 1), bus_viol);
            end
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1; start = 1'b0; base_addr = '0; burst_len = '0; num_bursts = '0; seed = '0;
        flip_en = 1'b0; flip_addr = '0; policy = 0; rec = 1'b0;
        gap_cnt = 0; busy_cnt = 0; bus_viol = 0; cyc_seen = 0; cyc_cnt = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_degenerate();
        test_single_beat();
        test_wait_states();
        test_error_inject();
        test_wrap();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
